mem_arbiter: RTL and testbench

Two-client arbiter that shares the single `main_memory` instance between the CPU's instruction-fetch path and its load/store data path. Each client issues a request with a level/ack handshake. The arbiter picks one client using round-robin priority, latches that client's request, drives the memory ports for one access cycle, and returns a registered one-cycle acknowledge with read data. It sits between the CPU control/datapath and `main_memory`, replacing the direct PC-to-read-address connection.

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main_memory port between the instruction-fetch
// client and the load/store client. Round-robin between the two clients, one
// memory access cycle per grant, registered one-cycle acknowledge.
//
//   state | meaning
//   IDLE  | no access in flight; arbitrate among both requests
//   SERVE | memory access cycle for the latched request of cur
//   RESP  | ack of cur is high; only the other client may be granted
module mem_arbiter #(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [width-1:0] if_addr,
   output logic             if_ack,
   output logic [width-1:0] if_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [width-1:0] d_addr,
   input  logic [width-1:0] d_wdata,
   output logic             d_ack,
   output logic [width-1:0] d_rdata,
   output logic [width-1:0] mem_read_address,
   input  logic [width-1:0] mem_read_data,
   output logic [width-1:0] mem_write_address,
   output logic [width-1:0] mem_write_data,
   output logic             mem_write_enable
);

   typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

   state_t           state_q;
   logic             cur_q;          // 0 = IF, 1 = D
   logic             last_grant_q;
   logic [width-1:0] lat_addr_q;
   logic             lat_we_q;
   logic [width-1:0] lat_wdata_q;
   logic [width-1:0] if_rdata_q;
   logic [width-1:0] d_rdata_q;
   logic             if_ack_q;
   logic             d_ack_q;
   logic             mem_we_q;

   logic             elig_if;
   logic             elig_d;
   logic             grant_d;        // some client is granted at this edge
   logic             sel_d;          // which client: 0 = IF, 1 = D

   // Eligibility and round-robin choice; in RESP the client being acked is masked.
   always_comb begin
      elig_if = 1'b0;
      elig_d  = 1'b0;
      if (state_q == IDLE) begin
         elig_if = if_req;
         elig_d  = d_req;
      end else if (state_q == RESP) begin
         elig_if = if_req & cur_q;
         elig_d  = d_req & ~cur_q;
      end
      grant_d = elig_if | elig_d;
      sel_d   = (elig_if & elig_d) ? ~last_grant_q : elig_d;
   end

   // Arbiter FSM with registered acks and write enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cur_q        <= 1'b0;
         last_grant_q <= 1'b1;
         lat_addr_q   <= '0;
         lat_we_q     <= 1'b0;
         lat_wdata_q  <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         if_ack_q     <= 1'b0;
         d_ack_q      <= 1'b0;
         mem_we_q     <= 1'b0;
      end else begin
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         mem_we_q <= 1'b0;
         case (state_q)
            IDLE, RESP: begin
               if (grant_d) begin
                  state_q      <= SERVE;
                  cur_q        <= sel_d;
                  last_grant_q <= sel_d;
                  lat_addr_q   <= sel_d ? d_addr : if_addr;
                  lat_we_q     <= sel_d & d_we;
                  lat_wdata_q  <= sel_d ? d_wdata : '0;
                  mem_we_q     <= sel_d & d_we;
               end else begin
                  state_q <= IDLE;
               end
            end
            SERVE: begin
               // Stores leave the client's read-data register untouched.
               if (!lat_we_q) begin
                  if (cur_q) d_rdata_q  <= mem_read_data;
                  else       if_rdata_q <= mem_read_data;
               end
               if (cur_q) d_ack_q  <= 1'b1;
               else       if_ack_q <= 1'b1;
               state_q <= RESP;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_ack            = if_ack_q;
   assign d_ack             = d_ack_q;
   assign if_rdata          = if_rdata_q;
   assign d_rdata           = d_rdata_q;
   assign mem_read_address  = lat_addr_q;
   assign mem_write_address = lat_addr_q;
   assign mem_write_data    = lat_wdata_q;
   assign mem_write_enable  = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural memory, directed timing scenarios and
// two randomized clients, checked by a scoreboard fed at request issue time.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic [31:0] mem_read_address;
   logic [31:0] mem_read_data;
   logic [31:0] mem_write_address;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;

   mem_arbiter #(.width(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
      .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
      .mem_write_enable(mem_write_enable)
   );

   always #5 clk = ~clk;

   // main_memory stand-in: combinational read, write on the rising edge
   logic [31:0] mem [0:63];
   assign mem_read_data = mem[mem_read_address[5:0]];
   always @(posedge clk) if (mem_write_enable) mem[mem_write_address[5:0]] <= mem_write_data;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: memory as the clients should see it, updated when a
   // store is issued (clients have one request outstanding each, IF never stores).
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } d_txn_t;

   logic [31:0] refmem [0:63];
   logic [31:0] if_exp_q [$];
   d_txn_t      d_exp_q [$];
   logic [31:0] if_rdata_exp = '0;
   logic [31:0] d_rdata_exp = '0;
   int          if_ack_cyc [$];
   int          d_ack_cyc [$];
   int          we_cycles = 0;
   d_txn_t      mon_t;

   // Monitor: pops the scoreboard on each ack, checks write cycles and held data.
   always @(negedge clk) begin
      if (!rst) begin
         if (if_ack || d_ack) check("ack_exclusive", {31'b0, if_ack & d_ack}, 32'd0);
         if (mem_write_enable) begin
            we_cycles++;
            if (d_exp_q.size() == 0 || !d_exp_q[0].we) begin
               checks++; failures++;
               $display("FAIL spurious_write: write enable high at addr %h, expected no write", mem_write_address);
            end else begin
               check("wr_addr", mem_write_address, d_exp_q[0].addr);
               check("wr_data", mem_write_data, d_exp_q[0].wdata);
            end
         end
         if (if_ack) begin
            if_ack_cyc.push_back(cyc);
            if (if_exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL if_ack_unexpected: if_ack=1, expected 0");
            end else if_rdata_exp = if_exp_q.pop_front();
         end
         if (d_ack) begin
            d_ack_cyc.push_back(cyc);
            if (d_exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL d_ack_unexpected: d_ack=1, expected 0");
            end else begin
               mon_t = d_exp_q.pop_front();
               if (!mon_t.we) d_rdata_exp = mon_t.rdata;
            end
         end
         check("if_rdata", if_rdata, if_rdata_exp);
         check("d_rdata", d_rdata, d_rdata_exp);
      end
   end

   task automatic issue_if(input logic [31:0] a);
      if_addr = a;
      if_req  = 1'b1;
      if_exp_q.push_back(refmem[a[5:0]]);
   endtask

   task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
      d_txn_t t;
      t.we = we; t.addr = a; t.wdata = wd;
      t.rdata = we ? 32'd0 : refmem[a[5:0]];
      if (we) refmem[a[5:0]] = wd;
      d_exp_q.push_back(t);
      d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
   endtask

   task automatic wait_ack(input bit is_d, input int lim, input string name);
      bit seen = 1'b0;
      for (int j = 0; j < lim && !seen; j++) begin
         @(negedge clk);
         if (is_d ? d_ack : if_ack) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s: no ack within %0d cycles, expected ack", name, lim);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      if_exp_q.delete();
      d_exp_q.delete();
      if_rdata_exp = '0;
      d_rdata_exp  = '0;
      #1;
      check("rst_if_ack", {31'b0, if_ack}, 32'd0);
      check("rst_d_ack", {31'b0, d_ack}, 32'd0);
      check("rst_we", {31'b0, mem_write_enable}, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_addr", mem_read_address, 32'd0);
      check("rst_wdata", mem_write_data, 32'd0);
   endtask

   function automatic int rel(input int q [$], input int i, input int c0);
      return (q.size() > i) ? q[i] - c0 : -1;
   endfunction

   task automatic if_client(input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         issue_if($urandom_range(0, 15));
         wait_ack(1'b0, 5, "if_ack_latency");
         @(posedge clk); #1;
         if_req = 1'b0;
      end
   endtask

   int n_stores = 0;
   task automatic d_client(input int n);
      logic we;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         we = 1'($urandom_range(0, 1));
         if (we) begin
            issue_d(1'b1, $urandom_range(16, 31), $urandom);
            n_stores++;
         end else issue_d(1'b0, $urandom_range(0, 31), 32'd0);
         wait_ack(1'b1, 5, "d_ack_latency");
         @(posedge clk); #1;
         d_req = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

   int c0;
   int we_base;
   logic [31:0] old3;

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i] = $urandom;
         refmem[i] = mem[i];
      end
      mem[5] = 32'hDEADBEEF;
      refmem[5] = 32'hDEADBEEF;

      // Single fetch after reset: address in cycle 1, ack and data in cycle 2.
      do_reset();
      @(posedge clk); #1 rst = 1'b0;
      c0 = cyc;
      issue_if(32'd5);
      @(negedge clk);
      @(negedge clk);
      check("t1_read_addr", mem_read_address, 32'd5);
      @(negedge clk);
      check("t1_if_ack_c2", {31'b0, if_ack}, 32'd1);
      check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
      @(posedge clk); #1 if_req = 1'b0;
      check("t1_no_write", we_cycles, 32'd0);

      // Store then load to the same address.
      repeat (2) @(posedge clk); #1;
      issue_d(1'b1, 32'd7, 32'h1234);
      @(negedge clk);
      @(negedge clk);
      check("t2_we_c1", {31'b0, mem_write_enable}, 32'd1);
      @(negedge clk);
      check("t2_d_ack_c2", {31'b0, d_ack}, 32'd1);
      check("t2_we_one_cycle", {31'b0, mem_write_enable}, 32'd0);
      @(posedge clk); #1 d_req = 1'b0;
      @(posedge clk); #1;
      issue_d(1'b0, 32'd7, 32'd0);
      wait_ack(1'b1, 5, "t2_load_ack");
      check("t2_load_data", d_rdata, 32'h1234);
      check("t2_if_rdata_kept", if_rdata, 32'hDEADBEEF);
      check("t2_write_count", we_cycles, 32'd1);
      @(posedge clk); #1 d_req = 1'b0;

      // Both requests held from reset: IF first, then alternation every 2 cycles.
      do_reset();
      if_req = 1'b1; if_addr = 32'd1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
      repeat (2) if_exp_q.push_back(refmem[1]);
      repeat (2) d_exp_q.push_back({1'b0, 32'd2, 32'd0, refmem[2]});
      if_ack_cyc.delete(); d_ack_cyc.delete();
      @(posedge clk); #1 rst = 1'b0;
      c0 = cyc;
      repeat (7) @(posedge clk); #1 if_req = 1'b0;
      repeat (2) @(posedge clk); #1 d_req = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("t3_if_ack1", rel(if_ack_cyc, 0, c0), 32'd2);
      check("t3_d_ack1", rel(d_ack_cyc, 0, c0), 32'd4);
      check("t3_if_ack2", rel(if_ack_cyc, 1, c0), 32'd6);
      check("t3_d_ack2", rel(d_ack_cyc, 1, c0), 32'd8);
      check("t3_if_ack_count", if_ack_cyc.size(), 32'd2);

      // One client held high: one access per 3 cycles.
      c0 = cyc;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd9;
      repeat (3) d_exp_q.push_back({1'b0, 32'd9, 32'd0, refmem[9]});
      if_ack_cyc.delete(); d_ack_cyc.delete();
      repeat (9) @(posedge clk); #1 d_req = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("t4_d_ack1", rel(d_ack_cyc, 0, c0), 32'd2);
      check("t4_d_ack2", rel(d_ack_cyc, 1, c0), 32'd5);
      check("t4_d_ack3", rel(d_ack_cyc, 2, c0), 32'd8);
      check("t4_d_ack_count", d_ack_cyc.size(), 32'd3);
      check("t4_no_if_ack", if_ack_cyc.size(), 32'd0);

      // Reset during the SERVE cycle of a store: nothing commits, no ack.
      old3 = mem[3];
      d_exp_q.push_back({1'b1, 32'd3, 32'hAAAA5555, 32'd0});
      d_we = 1'b1; d_addr = 32'd3; d_wdata = 32'hAAAA5555; d_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t5_in_serve", {31'b0, mem_write_enable}, 32'd1);
      #1 do_reset();
      d_req = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t5_no_d_ack", {31'b0, d_ack}, 32'd0);
      end
      check("t5_mem3_kept", mem[3], old3);

      // IF raised during the RESP cycle of a D access goes straight to SERVE.
      @(posedge clk); #1;
      c0 = cyc;
      if_ack_cyc.delete(); d_ack_cyc.delete();
      issue_d(1'b0, 32'd20, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      issue_if(32'd4);
      @(posedge clk); #1 d_req = 1'b0;
      @(negedge clk);
      check("t6_serve_addr", mem_read_address, 32'd4);
      @(posedge clk); #1;
      @(posedge clk); #1 if_req = 1'b0;
      check("t6_d_ack", rel(d_ack_cyc, 0, c0), 32'd2);
      check("t6_if_ack", rel(if_ack_cyc, 0, c0), 32'd4);

      // Randomized concurrent traffic from both clients.
      repeat (2) @(posedge clk); #1;
      we_base = we_cycles;
      fork
         if_client(60);
         d_client(60);
      join
      repeat (3) @(posedge clk); #1;
      check("rand_store_count", we_cycles - we_base, n_stores);
      check("rand_if_drained", if_exp_q.size(), 32'd0);
      check("rand_d_drained", d_exp_q.size(), 32'd0);
      for (int i = 0; i < 32; i++) check("final_mem", mem[i], refmem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
